// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
// State, operation and owner encodings used by the FSM and its latches.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   typedef enum logic [1:0] {
      IREAD  = 2'd0,
      DREAD  = 2'd1,
      DWRITE = 2'd2
   } mem_op_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_arb_timer.sv
// BUSY-cycle counter for the memory arbiter.
// Flags the last permitted cycle of a RAM access; TIMEOUT of 0 never fires.
module mem_arb_timer
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);
   localparam logic TO_ON = (TIMEOUT != 0);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_tc = TO_ON & i_en & (r_cnt == TC_VAL);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates pipeline instruction/data requests onto one variable-latency RAM.
// One transaction in flight: IDLE accepts, BUSY drives the RAM, RESP pulses the hit.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   output logic              ihit,
   output logic [DATA_W-1:0] iload,
   output logic              dhit,
   output logic [DATA_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [DATA_W-1:0] ramstore,
   input  logic [DATA_W-1:0] ramload,
   input  logic              ram_ready,
   output logic              mem_err
);

   arb_state_t        r_state;
   mem_op_t           r_op;
   owner_t            r_owner;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic [DATA_W-1:0] r_iload;
   logic [DATA_W-1:0] r_dload;
   logic              r_last_d;
   logic              r_err;

   logic w_ireq;
   logic w_dreq;
   logic w_pick_i;
   logic w_accept;
   logic w_busy;
   logic w_resp;
   logic w_tc;

   assign w_ireq   = iREN;
   assign w_dreq   = dREN | dWEN;
   // Contention goes to I only when D was served last.
   assign w_pick_i = w_ireq & (~w_dreq | r_last_d);
   assign w_accept = (r_state == IDLE) & (w_ireq | w_dreq);
   assign w_busy   = (r_state == BUSY);
   assign w_resp   = (r_state == RESP);

   mem_arb_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .i_clk (CLK),
      .i_rst (RST),
      .i_clr (w_accept),
      .i_en  (w_busy),
      .o_tc  (w_tc)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state  <= IDLE;
         r_op     <= IREAD;
         r_owner  <= OWN_I;
         r_addr   <= '0;
         r_data   <= '0;
         r_iload  <= '0;
         r_dload  <= '0;
         r_last_d <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_state <= BUSY;
                  r_data  <= dstore;
                  if (w_pick_i) begin
                     r_owner <= OWN_I;
                     r_op    <= IREAD;
                     r_addr  <= iaddr;
                  end else begin
                     r_owner <= OWN_D;
                     r_op    <= dWEN ? DWRITE : DREAD;
                     r_addr  <= daddr;
                  end
               end
            end
            BUSY: begin
               if (ram_ready) begin
                  r_state <= RESP;
                  if (r_owner == OWN_I) begin
                     r_iload <= ramload;
                  end else begin
                     r_dload <= ramload;
                  end
               end else if (w_tc) begin
                  r_state <= IDLE;
                  r_err   <= 1'b1;
               end
            end
            RESP: begin
               r_state  <= IDLE;
               r_last_d <= (r_owner == OWN_D);
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // A flushed requester no longer holds its request, so its hit is dropped.
   assign ihit     = w_resp & (r_owner == OWN_I) & w_ireq;
   assign dhit     = w_resp & (r_owner == OWN_D) & w_dreq;
   assign iload    = r_iload;
   assign dload    = r_dload;
   assign ramREN   = w_busy & (r_op != DWRITE);
   assign ramWEN   = w_busy & (r_op == DWRITE);
   assign ramaddr  = r_addr;
   assign ramstore = r_data;
   assign mem_err  = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized transactions against a transaction-level model.
// Every cycle checks strobes, hits, held load words and the sticky error flag.
module tb_mem_arbiter;

   localparam int TO = 4;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        iREN = 1'b0;
   logic        dREN = 1'b0;
   logic        dWEN = 1'b0;
   logic        ram_ready = 1'b0;
   logic [31:0] iaddr = '0;
   logic [31:0] daddr = '0;
   logic [31:0] dstore = '0;
   logic [31:0] ramload = '0;
   logic        ihit;
   logic        dhit;
   logic        ramREN;
   logic        ramWEN;
   logic        mem_err;
   logic [31:0] iload;
   logic [31:0] dload;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;

   int n_checks = 0;
   int n_err = 0;

   logic        m_last_d = 1'b0;
   logic        m_err = 1'b0;
   logic [31:0] m_iload = '0;
   logic [31:0] m_dload = '0;

   mem_arbiter #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .TIMEOUT (TO)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .iREN      (iREN),
      .iaddr     (iaddr),
      .dREN      (dREN),
      .dWEN      (dWEN),
      .daddr     (daddr),
      .dstore    (dstore),
      .ihit      (ihit),
      .iload     (iload),
      .dhit      (dhit),
      .dload     (dload),
      .ramREN    (ramREN),
      .ramWEN    (ramWEN),
      .ramaddr   (ramaddr),
      .ramstore  (ramstore),
      .ramload   (ramload),
      .ram_ready (ram_ready),
      .mem_err   (mem_err)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic ren, input logic wen,
                          input logic ih, input logic dh);
      chk({tag, ".ramREN"}, {31'b0, ramREN}, {31'b0, ren});
      chk({tag, ".ramWEN"}, {31'b0, ramWEN}, {31'b0, wen});
      chk({tag, ".ihit"}, {31'b0, ihit}, {31'b0, ih});
      chk({tag, ".dhit"}, {31'b0, dhit}, {31'b0, dh});
      chk({tag, ".iload"}, iload, m_iload);
      chk({tag, ".dload"}, dload, m_dload);
      chk({tag, ".mem_err"}, {31'b0, mem_err}, {31'b0, m_err});
   endtask

   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   // One transaction from IDLE to the following idle gap.
   // lat = BUSY cycle carrying ram_ready; lat > TO means it never comes.
   task automatic txn(input logic ir, input logic dr, input logic dw,
                      input int lat, input bit flush,
                      input logic [31:0] ia, input logic [31:0] da,
                      input logic [31:0] ds, input logic [31:0] rl);
      logic win_d;
      logic wr;
      logic [31:0] a;
      int nb;
      win_d = (dr | dw) && !(ir && m_last_d);
      wr = win_d && dw;
      a = win_d ? da : ia;
      nb = (lat > TO) ? TO : lat;
      iREN = ir; dREN = dr; dWEN = dw;
      iaddr = ia; daddr = da; dstore = ds;
      ram_ready = 1'($urandom_range(0, 1));
      ramload = $urandom;
      #1 chk_out("idle", 0, 0, 0, 0);
      tick();
      for (int k = 1; k <= nb; k++) begin
         iaddr = $urandom; daddr = $urandom; dstore = $urandom;
         if (flush) begin
            if (win_d) begin
               dREN = 0; dWEN = 0;
            end else begin
               iREN = 0;
            end
         end
         ram_ready = (k == lat);
         ramload = (k == lat) ? rl : $urandom;
         #1 chk_out("busy", !wr, wr, 0, 0);
         chk("busy.ramaddr", ramaddr, a);
         if (wr) chk("busy.ramstore", ramstore, ds);
         tick();
         if (k == lat) begin
            if (win_d) m_dload = rl;
            else m_iload = rl;
         end
      end
      if (lat <= TO) begin
         ram_ready = 1'($urandom_range(0, 1));
         ramload = $urandom;
         #1 chk_out("resp", 0, 0, !win_d && !flush, win_d && !flush);
         if (!win_d && !flush) chk("resp.iload_val", iload, rl);
         if (win_d && !flush) chk("resp.dload_val", dload, rl);
         tick();
         m_last_d = win_d;
      end else begin
         m_err = 1'b1;
      end
      iREN = 0; dREN = 0; dWEN = 0;
      ram_ready = 1'($urandom_range(0, 1));
      #1 chk_out("gap", 0, 0, 0, 0);
      tick();
   endtask

   initial begin
      logic ir, dr, dw;
      int lat;
      bit fl;

      // Reset state
      #1 chk_out("reset", 0, 0, 0, 0);
      chk("reset.ramaddr", ramaddr, 32'h0);
      chk("reset.ramstore", ramstore, 32'h0);
      @(negedge CLK);
      RST = 0;

      // Continuous I+D contention with an always-ready RAM
      iaddr = 32'h0000_1000;
      daddr = 32'h0000_2000;
      for (int k = 0; k < 12; k++) begin
         logic own_d;
         own_d = ((k / 3) % 2) == 0;
         iREN = 1; dREN = 1; dWEN = 0;
         ram_ready = 1;
         ramload = 32'hA000_0000 + k;
         #1;
         if (k % 3 == 1) begin
            chk_out("arb.busy", 1, 0, 0, 0);
            chk("arb.ramaddr", ramaddr, own_d ? 32'h2000 : 32'h1000);
         end else if (k % 3 == 2) begin
            chk_out("arb.resp", 0, 0, !own_d, own_d);
         end else begin
            chk_out("arb.idle", 0, 0, 0, 0);
         end
         tick();
         if (k % 3 == 1) begin
            if (own_d) m_dload = 32'hA000_0000 + k;
            else m_iload = 32'hA000_0000 + k;
         end
      end
      m_last_d = 1'b0;
      iREN = 0; dREN = 0; ram_ready = 0;
      #1 chk_out("arb.gap", 0, 0, 0, 0);
      tick();

      // Single read, write with 3-cycle RAM, flush, timeout, recovery
      txn(0, 1, 0, 1, 0, 32'h0, 32'h40, 32'h0, 32'hDEADBEEF);
      txn(0, 0, 1, 3, 0, 32'h0, 32'h80, 32'h1234_5678, 32'h5555_AAAA);
      txn(1, 0, 0, 2, 1, 32'h100, 32'h0, 32'h0, 32'hCAFE_F00D);
      txn(0, 1, 0, TO + 1, 0, 32'h0, 32'h44, 32'h0, 32'h0);
      txn(1, 0, 0, 1, 0, 32'h200, 32'h0, 32'h0, 32'h0BAD_C0DE);
      txn(1, 1, 1, 1, 0, 32'h300, 32'h304, 32'h7777_0000, 32'h1111_2222);

      // Randomized transactions
      for (int t = 0; t < 40; t++) begin
         ir = 1'($urandom_range(0, 1));
         dr = 1'($urandom_range(0, 1));
         dw = 1'($urandom_range(0, 1));
         if (!ir && !dr && !dw) ir = 1;
         lat = $urandom_range(1, TO + 1);
         fl = ($urandom_range(0, 3) == 0);
         txn(ir, dr, dw, lat, fl, $urandom, $urandom, $urandom, $urandom);
      end

      // Async reset in the middle of BUSY
      dREN = 1; daddr = 32'h0000_0ABC; ram_ready = 0;
      #1 chk_out("ar.idle", 0, 0, 0, 0);
      tick();
      #1 chk("ar.busy.ramREN", {31'b0, ramREN}, 32'h1);
      #2 RST = 1;
      #1;
      m_err = 0; m_iload = '0; m_dload = '0; m_last_d = 0;
      chk_out("ar.inreset", 0, 0, 0, 0);
      chk("ar.ramaddr", ramaddr, 32'h0);
      @(negedge CLK);
      RST = 0; dREN = 0; ram_ready = 1; ramload = 32'hFFFF_0000;
      for (int k = 0; k < 4; k++) begin
         #1 chk_out("ar.after", 0, 0, 0, 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Responder side of the pipeline's memory handshake. The datapath and hazard logic raise iREN/dREN/dWEN and wait on ihit/dhit; this block answers them.
- Arbitrates instruction and data requests onto a single-ported RAM with variable latency.
- Registers each transaction, tracks completion and timeout, and returns one-cycle hit pulses with load data.
- Sits between the pipeline's memory interface and the RAM model/controller.

Parameters:
ADDR_W, 32, byte-address width
DATA_W, 32, word width
TIMEOUT, 255, max BUSY cycles before abort (0 disables timeout)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
iREN  in  1  instruction read request
iaddr  in  ADDR_W  instruction address
dREN  in  1  data read request
dWEN  in  1  data write request
daddr  in  ADDR_W  data address
dstore  in  DATA_W  store data
ihit  out  1  instruction access complete (1-cycle pulse)
iload  out  DATA_W  instruction word, valid while ihit
dhit  out  1  data access complete (1-cycle pulse)
dload  out  DATA_W  load word, valid while dhit
ramREN  out  1  RAM read strobe
ramWEN  out  1  RAM write strobe
ramaddr  out  ADDR_W  RAM address
ramstore  out  DATA_W  RAM write data
ramload  in  DATA_W  RAM read data, valid with ram_ready
ram_ready  in  1  RAM access done this cycle
mem_err  out  1  sticky timeout flag

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; last_d=0; timeout counter 0; latched addr/data/op 0. Reset mid-transaction abandons it and produces no hit.
- State encoding lives in the package: IDLE, BUSY, RESP.
- IDLE, sampling requests:
  - Both classes pending: serve I if last_d=1, else D (alternating, no starvation).
  - Only one class pending: serve it.
  - dREN and dWEN both high: treat as write.
  - On accept: latch addr, store data, op (IREAD/DREAD/DWRITE), owner; clear counter; go to BUSY.
- BUSY:
  - ramaddr/ramstore come from latches only, never from live inputs.
  - ramREN=1 for IREAD/DREAD; ramWEN=1 for DWRITE.
  - Counter increments each BUSY cycle.
  - ram_ready=1: capture ramload into the owner's load register, go to RESP.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: set mem_err, go to IDLE, no hit.
- RESP:
  - Owner's hit=1 only if the owner's request is still asserted this cycle. Otherwise the result is dropped (requester flushed); the RAM op is complete regardless.
  - last_d updates to owner==D.
  - New requests are ignored; always returns to IDLE.
- Latency: request seen in IDLE at cycle N, ram_ready in first BUSY cycle (N+1) → hit in cycle N+2.
- Back-to-back requests from the same requester restart at IDLE, so minimum issue interval is 3 cycles.
- ihit and dhit are never both high. Hits last exactly one cycle.
- iload/dload hold their last captured value between hits.
- ramREN/ramWEN are 0 outside BUSY. ram_ready outside BUSY is ignored.
- mem_err clears only on RST.

Decomposition:
- Package mem_arb_pkg: arb_state_t enum (IDLE, BUSY, RESP); mem_op_t enum (IREAD, DREAD, DWRITE); owner_t (OWN_I, OWN_D).
- Sub-module mem_arb_timer: counter with clear/enable and terminal-count output driven by TIMEOUT.
- FSM, latches and hit logic stay in mem_arbiter.

Test Plan:
- Single read: dREN=1, daddr=0x40, ram_ready at first BUSY cycle with ramload=0xDEADBEEF → ramREN=1 and ramaddr=0x40 for 1 cycle; dhit=1 two cycles after request with dload=0xDEADBEEF; ihit=0.
- Write: dWEN=1, daddr=0x80, dstore=0x12345678, ram_ready after 3 cycles → ramWEN=1 held 3 cycles with ramstore=0x12345678; then dhit for 1 cycle; no ramREN.
- Arbitration: iREN and dREN held continuously, 1-cycle RAM → grants alternate D,I,D,I; each hit pulse is separated by 3 cycles.
- Flush: iREN dropped while BUSY → transaction completes, ihit stays 0, FSM back to IDLE.
- Timeout: TIMEOUT=4, dREN, ram_ready never asserted → ramREN high 4 cycles, then mem_err=1 sticky, no dhit, next iREN serviced normally.
- Async reset: RST asserted mid-BUSY between clock edges → ramREN/ramWEN/hits drop immediately; after release no hit is produced for the abandoned transaction.
